// File: rtl/ecc_req_scheduler_if.sv
// Requester, response and ECC-core signal bundle for the ECC request scheduler.
// The slave modport is the scheduler; the master modport is the requesters plus the core.
interface ecc_req_scheduler_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [3:0]              req_mode;
    logic [3:0]              req_width;
    logic [2*DATA_WIDTH-1:0] req_data;
    logic [2*DATA_WIDTH-1:0] req_noise;

    logic [1:0]              rsp_valid;
    logic [1:0]              rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic [1:0]              rsp_errors;
    logic [1:0]              rsp_status;

    logic                    core_start;
    logic [1:0]              core_mode;
    logic [1:0]              core_width;
    logic [DATA_WIDTH-1:0]   core_data;
    logic [DATA_WIDTH-1:0]   core_noise;
    logic                    core_done;
    logic [DATA_WIDTH-1:0]   core_data_out;
    logic [1:0]              core_num_errors;

    logic                    busy;

    modport slave (
        input  req_valid, req_mode, req_width, req_data, req_noise,
        input  rsp_ready, core_done, core_data_out, core_num_errors,
        output req_ready, rsp_valid, rsp_data, rsp_errors, rsp_status,
        output core_start, core_mode, core_width, core_data, core_noise, busy
    );

    modport master (
        output req_valid, req_mode, req_width, req_data, req_noise,
        output rsp_ready, core_done, core_data_out, core_num_errors,
        input  req_ready, rsp_valid, rsp_data, rsp_errors, rsp_status,
        input  core_start, core_mode, core_width, core_data, core_noise, busy
    );
endinterface

// File: rtl/ecc_req_scheduler.sv
// Two-requester round-robin scheduler for a shared ECC core: one job in flight,
// start pulse, done-or-timeout wait, and a registered valid/ready response.
module ecc_req_scheduler #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 15,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    ecc_req_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [1:0]       MODE_ILLEGAL = 2'b11;
    localparam logic [1:0]       ST_OK        = 2'b00;
    localparam logic [1:0]       ST_TIMEOUT   = 2'b01;
    localparam logic [1:0]       ST_ILLEGAL   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  owner_reg, last_reg;
    logic [1:0]            core_mode_reg, core_width_reg;
    logic [DATA_WIDTH-1:0] core_data_reg, core_noise_reg, rsp_data_reg;
    logic [1:0]            rsp_valid_reg, rsp_errors_reg, rsp_status_reg;

    logic [1:0]            mode_slice  [2];
    logic [1:0]            width_slice [2];
    logic [DATA_WIDTH-1:0] data_slice  [2];
    logic [DATA_WIDTH-1:0] noise_slice [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slice
            assign mode_slice[gi]  = bus.req_mode[2*gi +: 2];
            assign width_slice[gi] = bus.req_width[2*gi +: 2];
            assign data_slice[gi]  = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign noise_slice[gi] = bus.req_noise[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    logic grant_valid, grant_idx, accept, illegal, timeout_hit, rsp_done;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (bus.req_valid)
            2'b01:   begin grant_valid = 1'b1; grant_idx = 1'b0;      end
            2'b10:   begin grant_valid = 1'b1; grant_idx = 1'b1;      end
            2'b11:   begin grant_valid = 1'b1; grant_idx = ~last_reg; end
            default: ;
        endcase
    end

    assign accept      = (state_reg == IDLE) && grant_valid;
    assign illegal     = (mode_slice[grant_idx] == MODE_ILLEGAL);
    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign rsp_done    = bus.rsp_ready[owner_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = illegal ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.core_done || timeout_hit) state_next = RESP;
            RESP:    if (rsp_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is masked during reset so no accept is advertised before the FSM is live.
    always_comb begin
        bus.req_ready = 2'b00;
        if (accept && !rst) bus.req_ready[grant_idx] = 1'b1;
        bus.busy       = (state_reg != IDLE);
        bus.core_start = (state_reg == ISSUE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_reg       <= 1'b1;
            core_mode_reg  <= '0;
            core_width_reg <= '0;
            core_data_reg  <= '0;
            core_noise_reg <= '0;
            rsp_valid_reg  <= '0;
            rsp_data_reg   <= '0;
            rsp_errors_reg <= '0;
            rsp_status_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    core_mode_reg  <= mode_slice[grant_idx];
                    core_width_reg <= width_slice[grant_idx];
                    core_data_reg  <= data_slice[grant_idx];
                    core_noise_reg <= noise_slice[grant_idx];
                    owner_reg      <= grant_idx;
                    last_reg       <= grant_idx;
                    if (illegal) begin
                        rsp_valid_reg  <= 2'b01 << grant_idx;
                        rsp_data_reg   <= '0;
                        rsp_errors_reg <= 2'b00;
                        rsp_status_reg <= ST_ILLEGAL;
                    end
                end
                ISSUE: cnt_reg <= '0;
                WAIT: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    // A done on the last wait cycle still counts as success.
                    if (bus.core_done) begin
                        rsp_valid_reg  <= 2'b01 << owner_reg;
                        rsp_data_reg   <= bus.core_data_out;
                        rsp_errors_reg <= bus.core_num_errors;
                        rsp_status_reg <= ST_OK;
                    end else if (timeout_hit) begin
                        rsp_valid_reg  <= 2'b01 << owner_reg;
                        rsp_data_reg   <= '0;
                        rsp_errors_reg <= 2'b00;
                        rsp_status_reg <= ST_TIMEOUT;
                    end
                end
                RESP: if (rsp_done) rsp_valid_reg <= 2'b00;
                default: ;
            endcase
        end
    end

    assign bus.core_mode  = core_mode_reg;
    assign bus.core_width = core_width_reg;
    assign bus.core_data  = core_data_reg;
    assign bus.core_noise = core_noise_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_data   = rsp_data_reg;
    assign bus.rsp_errors = rsp_errors_reg;
    assign bus.rsp_status = rsp_status_reg;
endmodule

// File: doc/ecc_req_scheduler.md
Name:
ecc_req_scheduler

Overview:
Arbitrates two requesters, e.g. the host path and a self-test engine, for the single shared ECC encode/decode core. It latches the winning descriptor (mode, width, data, noise) and pulses the core start. It then waits for the core's done indication, or a timeout, and returns the result with status to the owning requester over a valid/ready response. One job is in flight at a time.

Parameters:
DATA_WIDTH, 32, width of data/noise/result words.
TIMEOUT_CYCLES, 15, max WAIT cycles before abort; legal range 2..255.
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived, do not override).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  2  per-requester request valid; bit i = requester i.
req_ready  out  2  per-requester accept; transfer when valid&ready.
req_mode  in  4  {req1,req0} 2-bit mode each: 00 encode, 01 decode, 10 full channel, 11 illegal.
req_width  in  4  {req1,req0} 2-bit codeword-width select each.
req_data  in  2*DATA_WIDTH  {req1,req0} input words.
req_noise  in  2*DATA_WIDTH  {req1,req0} noise masks.
rsp_valid  out  2  one-hot response valid to owning requester.
rsp_ready  in  2  per-requester response accept.
rsp_data  out  DATA_WIDTH  result word (shared bus).
rsp_errors  out  2  error count reported by core.
rsp_status  out  2  00 ok, 01 timeout, 10 illegal mode.
core_start  out  1  single-cycle start pulse to ECC core.
core_mode  out  2  latched mode to core.
core_width  out  2  latched width select to core.
core_data  out  DATA_WIDTH  latched data to core.
core_noise  out  DATA_WIDTH  latched noise to core.
core_done  in  1  core completion pulse.
core_data_out  in  DATA_WIDTH  core result.
core_num_errors  in  2  core error count.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0, including req_ready and all core_* registers. Last-served pointer = 1, so requester 0 has priority first. Reset mid-job aborts without a response. Any later core_done is ignored.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. An illegal mode goes IDLE -> RESP directly.
- IDLE, grant:
  - Only one req_valid set: grant that requester.
  - Both set: grant the one not last served.
  - req_ready[g] is combinational (state==IDLE && grant g). At most one bit is high.
  - On accept: latch mode/width/data/noise from slice g, record owner=g, update pointer.
  - Go to ISSUE, or to RESP with status 10, data 0, errors 0 if mode==11.
- ISSUE: core_start=1 for exactly this cycle. Timeout counter cleared to 0. Next state WAIT.
- Core inputs: core_mode/width/data/noise hold their latched values from ISSUE until the next accept.
- WAIT:
  - Counter increments each cycle.
  - core_done=1: capture core_data_out and core_num_errors, status 00, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: data 0, errors 0, status 01, go to RESP.
  - core_done on the final WAIT cycle wins over timeout.
- core_done outside WAIT is ignored.
- RESP: rsp_valid[owner]=1. rsp_data/errors/status are held stable until rsp_ready[owner]=1, then go to IDLE. rsp_ready of the non-owner is ignored. No new grant while in RESP.
- rsp_* are registered. rsp_valid is 0 outside RESP. rsp_data/errors/status keep their last values outside RESP.
- Latency:
  - Accept at cycle A, core_start at A+1, first WAIT cycle A+2.
  - core_done at cycle D gives rsp_valid at D+1.
  - Earliest re-accept is the cycle after the rsp handshake.
- A requester dropping req_valid before accept is legal. No grant is then issued to it.

Test Plan:
- Req0 mode 00, width 01, data 0x0000_01A5; core_done 3 cycles after core_start with data_out 0x0000_3C5A, errors 00 -> single core_start, rsp_valid=01 one cycle after done, rsp_data 0x0000_3C5A, status 00.
- Both requesters valid continuously from reset with rsp_ready=11 -> grants alternate 0,1,0,1 over 4 jobs; each core_start carries the matching requester's data.
- core_done never asserted, TIMEOUT_CYCLES=15, core_start at cycle S -> rsp_valid at S+16, status 01, rsp_data 0. Repeat with done at S+15 -> status 00.
- rsp_ready[1] held low 4 cycles on a req1 mode 10 job with errors 10 -> rsp_valid=10 and data stable 4+ cycles; req_ready stays 00 despite req0 valid.
- Req1 mode 11 -> no core_start, rsp_valid=10 one cycle after accept, status 10, errors 00.
- rst pulsed during WAIT, then core_done arrives -> all outputs 0, no response; next req0 job completes normally with req0 priority.
